sp3_demux: RTL and testbench

//  Receive-side demux for the SP3 dual link. Each 32-bit MGT parallel word carries two
//  bit-interleaved serial streams (even bits = lane A, odd bits = lane B). The block
//  de-interleaves both lanes, assembles 32-bit words at half the MGT word rate, and gives

---
 rtl/sp3_demux_pkg.sv | 25 ++
 rtl/sp3_demux_lane.sv | 58 +++++
 rtl/sp3_demux.sv | 57 +++++
 tb/tb_sp3_demux.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/sp3_demux_pkg.sv
// Shared widths and the lane de-interleave helper for the SP3 receive demux.
package sp3_demux_pkg;

  localparam int CHUNK_W = 16;
  localparam int WORD_W  = 32;
  localparam int HIST_W  = 64;
  localparam int OFF_W   = 5;

  typedef enum logic {
    LANE_A = 1'b0,
    LANE_B = 1'b1
  } lane_e;

  // Lane A owns the even bits of the MGT word, lane B the odd bits.
  function automatic logic [CHUNK_W-1:0] deinterleave(input logic [WORD_W-1:0] word,
                                                      input lane_e lane);
    logic [CHUNK_W-1:0] chunk;
    chunk = '0;
    for (int i = 0; i < CHUNK_W; i++) begin
      chunk[i] = word[2*i + int'(lane)];
    end
    return chunk;
  endfunction

endpackage

// File: rtl/sp3_demux_lane.sv
// One SP3 lane: 64-bit history, word capture at a slippable bit offset,
// and rising-edge bitslip with a holdoff window.
module sp3_demux_lane
  import sp3_demux_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [CHUNK_W-1:0] i_chunk,
  input  logic               i_capture,
  input  logic               i_bitslip,
  output logic [WORD_W-1:0]  o_word
);

  localparam int HOLD_W = $clog2(HOLDOFF_CYCLES + 1);

  logic [HIST_W-1:0] r_hist;
  logic [OFF_W-1:0]  r_off;
  logic              r_slip_d;
  logic [HOLD_W-1:0] r_holdoff;
  logic [WORD_W-1:0] r_word;

  logic [HIST_W-1:0] w_next_hist;
  logic              w_slip_rise;
  logic              w_slip_go;

  // Newest chunk enters at the top, so older serial bits sit at lower indices.
  assign w_next_hist = {i_chunk, r_hist[HIST_W-1:CHUNK_W]};
  assign w_slip_rise = i_bitslip & ~r_slip_d;
  assign w_slip_go   = w_slip_rise && (r_holdoff == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hist    <= '0;
      r_off     <= '0;
      r_slip_d  <= 1'b0;
      r_holdoff <= '0;
      r_word    <= '0;
    end else begin
      r_hist   <= w_next_hist;
      r_slip_d <= i_bitslip;
      if (w_slip_go) begin
        r_off     <= r_off + OFF_W'(1);
        r_holdoff <= HOLD_W'(HOLDOFF_CYCLES);
      end else if (r_holdoff != '0) begin
        r_holdoff <= r_holdoff - HOLD_W'(1);
      end
      // Capture uses the pre-slip offset; a slip on this edge shows at the next capture.
      if (i_capture) begin
        r_word <= w_next_hist[r_off +: WORD_W];
      end
    end
  end

  assign o_word = r_word;

endmodule

// File: rtl/sp3_demux.sv
// SP3 dual-link receive demux: splits the interleaved MGT word into two lanes
// and produces the half-rate clock the assembled words are aligned to.
module sp3_demux
  import sp3_demux_pkg::*;
#(
  parameter int HOLDOFF_CYCLES = 16
) (
  input  logic              mgtclk,
  input  logic              reset,
  input  logic [WORD_W-1:0] mgtword,
  input  logic              bitslip_a,
  input  logic              bitslip_b,
  output logic              mgtclk_div2,
  output logic [WORD_W-1:0] word_a,
  output logic [WORD_W-1:0] word_b
);

  logic               r_div2;
  logic [CHUNK_W-1:0] w_chunk_a;
  logic [CHUNK_W-1:0] w_chunk_b;

  always_ff @(posedge mgtclk or negedge reset) begin
    if (!reset) begin
      r_div2 <= 1'b0;
    end else begin
      r_div2 <= ~r_div2;
    end
  end

  assign mgtclk_div2 = r_div2;
  assign w_chunk_a   = deinterleave(mgtword, LANE_A);
  assign w_chunk_b   = deinterleave(mgtword, LANE_B);

  // Capture on the edge where div2 falls, i.e. while it is currently high.
  sp3_demux_lane #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_lane_a (
    .clk       (mgtclk),
    .rst_n     (reset),
    .i_chunk   (w_chunk_a),
    .i_capture (r_div2),
    .i_bitslip (bitslip_a),
    .o_word    (word_a)
  );

  sp3_demux_lane #(
    .HOLDOFF_CYCLES(HOLDOFF_CYCLES)
  ) u_lane_b (
    .clk       (mgtclk),
    .rst_n     (reset),
    .i_chunk   (w_chunk_b),
    .i_capture (r_div2),
    .i_bitslip (bitslip_b),
    .o_word    (word_b)
  );

endmodule

// File: tb/tb_sp3_demux.sv
// Directed bench for sp3_demux: TX pattern fed with a 5-bit serial phase offset,
// so 27 slips on a lane bring it into alignment from reset.
module tb_sp3_demux;

  localparam logic [31:0] TX_A  = 32'hAAFF00FF;
  localparam logic [31:0] TX_B  = 32'hF0F0AA00;
  localparam int          PHASE = 5;

  logic        mgtclk    = 1'b0;
  logic        reset     = 1'b0;
  logic        bitslip_a = 1'b0;
  logic        bitslip_b = 1'b0;
  logic [31:0] mgtword   = '0;
  logic        mgtclk_div2;
  logic [31:0] word_a;
  logic [31:0] word_b;

  int n_checks = 0;
  int n_fail   = 0;
  int k_cnt    = 0;

  sp3_demux #(.HOLDOFF_CYCLES(16)) dut (
    .mgtclk      (mgtclk),
    .reset       (reset),
    .mgtword     (mgtword),
    .bitslip_a   (bitslip_a),
    .bitslip_b   (bitslip_b),
    .mgtclk_div2 (mgtclk_div2),
    .word_a      (word_a),
    .word_b      (word_b)
  );

  // ---------------- clock ----------------
  always #5 mgtclk = ~mgtclk;

  // ---------------- stimulus helpers ----------------
  function automatic logic [31:0] lane_word(input int k);
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] w;
    int n;
    a = TX_A;
    b = TX_B;
    w = '0;
    for (int i = 0; i < 16; i++) begin
      n = (16 * k + i + PHASE) % 32;
      w[2*i]   = a[n];
      w[2*i+1] = b[n];
    end
    return w;
  endfunction

  task automatic cyc();
    @(negedge mgtclk);
    mgtword = lane_word(k_cnt);
    k_cnt++;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    bitslip_a = 1'b0;
    bitslip_b = 1'b0;
    repeat (3) @(negedge mgtclk);
    mgtword = lane_word(0);
    k_cnt   = 1;
    reset   = 1'b1;
  endtask

  task automatic slip(input int na, input int nb);
    int n;
    n = (na > nb) ? na : nb;
    for (int s = 0; s < n; s++) begin
      bitslip_a = (s < na);
      bitslip_b = (s < nb);
      repeat (3) cyc();
      bitslip_a = 1'b0;
      bitslip_b = 1'b0;
      repeat (17) cyc();
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_div2_rise();
    logic prev;
    bit   seen;
    seen = 1'b0;
    for (int c = 0; c < 4 && !seen; c++) begin
      prev = mgtclk_div2;
      cyc();
      if (!prev && mgtclk_div2) seen = 1'b1;
    end
    if (!seen) begin
      n_checks++;
      n_fail++;
      $display("FAIL div2_rise_timeout: got no rising edge expected one within 4 cycles");
    end
  endtask

  task automatic check_words(input string name, input logic [31:0] ea, input logic [31:0] eb);
    wait_div2_rise();
    check({name, "_word_a"}, word_a, ea);
    check({name, "_word_b"}, word_b, eb);
  endtask

  // ---------------- monitor: div2 toggles every cycle, words move only on div2 fall ----------------
  int          toggle_err = 0;
  int          chg_err    = 0;
  bit          mon_valid  = 1'b0;
  logic        prev_div2;
  logic [31:0] prev_a;
  logic [31:0] prev_b;

  always @(negedge mgtclk) begin
    if (!reset) begin
      mon_valid <= 1'b0;
    end else begin
      if (mon_valid) begin
        if (mgtclk_div2 == prev_div2) toggle_err <= toggle_err + 1;
        if (((word_a != prev_a) || (word_b != prev_b)) && !(prev_div2 && !mgtclk_div2))
          chg_err <= chg_err + 1;
      end
      prev_div2 <= mgtclk_div2;
      prev_a    <= word_a;
      prev_b    <= word_b;
      mon_valid <= 1'b1;
    end
  end

  // ---------------- vector table ----------------
  typedef struct {
    int          na;
    int          nb;
    logic [31:0] exp_a;
    logic [31:0] exp_b;
  } vec_t;

  vec_t vecs[7];

  // ---------------- main sequence ----------------
  initial begin
    int   slips;
    bit   aligned;
    time  t0;
    time  t1;

    // Cumulative slips from reset; word = TX rotated right by (offset + 5) mod 32.
    vecs[0] = '{na: 0,  nb: 0,  exp_a: 32'hFD57F807, exp_b: 32'h07878550};
    vecs[1] = '{na: 3,  nb: 0,  exp_a: 32'hFFAAFF00, exp_b: 32'h07878550};
    vecs[2] = '{na: 0,  nb: 11, exp_a: 32'hFFAAFF00, exp_b: 32'hAA00F0F0};
    vecs[3] = '{na: 8,  nb: 0,  exp_a: 32'h00FFAAFF, exp_b: 32'hAA00F0F0};
    vecs[4] = '{na: 16, nb: 16, exp_a: 32'hAAFF00FF, exp_b: 32'hF0F0AA00};
    vecs[5] = '{na: 4,  nb: 0,  exp_a: 32'hFAAFF00F, exp_b: 32'hF0F0AA00};
    vecs[6] = '{na: 1,  nb: 4,  exp_a: 32'hFD57F807, exp_b: 32'h0F0F0AA0};

    // Power-on reset state.
    @(negedge mgtclk);
    check("por_div2", {31'd0, mgtclk_div2}, 32'd0);
    check("por_word_a", word_a, 32'd0);
    check("por_word_b", word_b, 32'd0);
    do_reset();
    repeat (8) cyc();

    for (int i = 0; i < 7; i++) begin
      slip(vecs[i].na, vecs[i].nb);
      check_words($sformatf("vec%0d", i), vecs[i].exp_a, vecs[i].exp_b);
    end

    // Asynchronous reset mid-stream, observed before any clock edge.
    wait_div2_rise();
    #2 reset = 1'b0;
    #1;
    check("areset_div2", {31'd0, mgtclk_div2}, 32'd0);
    check("areset_word_a", word_a, 32'd0);
    check("areset_word_b", word_b, 32'd0);
    do_reset();

    // Alignment search from offset 0; 27 slips are needed for a 5-bit TX phase.
    slips   = 0;
    aligned = 1'b0;
    for (int it = 0; it < 40 && !aligned; it++) begin
      wait_div2_rise();
      if (word_a == TX_A) begin
        aligned = 1'b1;
      end else begin
        slip(1, 1);
        slips++;
      end
    end
    check("align_slips", slips, 32'd27);
    wait_div2_rise();
    check_words("aligned", TX_A, TX_B);

    // 32 slips on lane A wrap the offset back; lane B must not move.
    for (int s = 0; s < 32; s++) begin
      slip(1, 0);
      check($sformatf("wrap_b_%0d", s), word_b, TX_B);
    end
    check_words("wrap", TX_A, TX_B);

    // One slip on lane B only.
    slip(0, 1);
    check_words("indep", TX_A, 32'h78785500);

    // Second rising edge 4 cycles after the first falls inside holdoff.
    bitslip_a = 1'b1;
    cyc();
    bitslip_a = 1'b0;
    repeat (3) cyc();
    bitslip_a = 1'b1;
    cyc();
    bitslip_a = 1'b0;
    repeat (20) cyc();
    check_words("holdoff", 32'hD57F807F, 32'h78785500);

    // div2 period in time units (mgtclk period is 10).
    wait_div2_rise();
    t0 = $time;
    wait_div2_rise();
    t1 = $time;
    check("div2_period", 32'(t1 - t0), 32'd20);

    repeat (4) cyc();
    check("div2_toggle_errors", toggle_err, 32'd0);
    check("word_change_off_edge", chg_err, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
